// File: rtl/luma_frame_stat.sv
// luma_frame_stat: per-frame luma sum/min/max/pixel/line statistics with 3-clk video pass-through.
// Optional ROI window enabled by defining LUMA_FRAME_STAT_ROI_EN.
module luma_frame_stat #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COE_WIDTH   = 16,
  parameter int COE_SHIFT   = 6,
  parameter int CNT_WIDTH   = 12,
  parameter int SUM_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef LUMA_FRAME_STAT_ROI_EN
  input  logic [CNT_WIDTH-1:0]     roi_x0_i,
  input  logic [CNT_WIDTH-1:0]     roi_x1_i,
  input  logic [CNT_WIDTH-1:0]     roi_y0_i,
  input  logic [CNT_WIDTH-1:0]     roi_y1_i,
`endif
  input  logic [COE_WIDTH-1:0]     ycoe0_i,
  input  logic [COE_WIDTH-1:0]     ycoe1_i,
  input  logic [COE_WIDTH-1:0]     ycoe2_i,
  input  logic [3*PIXEL_WIDTH-1:0] di_i,
  input  logic                     de_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  output logic [3*PIXEL_WIDTH-1:0] do_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic [SUM_WIDTH-1:0]     stat_sum_o,
  output logic [PIXEL_WIDTH-1:0]   stat_min_o,
  output logic [PIXEL_WIDTH-1:0]   stat_max_o,
  output logic [2*CNT_WIDTH-1:0]   stat_pixcnt_o,
  output logic [CNT_WIDTH-1:0]     stat_linecnt_o,
  output logic                     stat_ovf_o,
  output logic                     stat_valid_o
);
  localparam int PW  = PIXEL_WIDTH;
  localparam int PRW = PW + COE_WIDTH;
  localparam int SW2 = PRW + 2;
  localparam int DW  = 3 * PW + 3;
  localparam int PCW = 2 * CNT_WIDTH;
  localparam int SW1 = SUM_WIDTH + 1;
  typedef enum logic [1:0] {S_SYNC, S_ACC, S_DONE} state_t;
  state_t               state_q, state_d;
  logic [PRW-1:0]       p_q [3];
  logic [PRW-1:0]       p_d [3];
  logic [DW-1:0]        d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [SW2-1:0]       s_q, s_d, sh;
  logic [PW-1:0]        y_q, y_d;
  logic                 de_prev_q, de_prev_d, vs_prev_q, vs_prev_d;
  logic [SUM_WIDTH-1:0] sum_acc_q, sum_acc_d, sum_b;
  logic [SW1-1:0]       sum_ext;
  logic [PW-1:0]        min_acc_q, min_acc_d, min_b, max_acc_q, max_acc_d, max_b;
  logic [PCW-1:0]       pix_acc_q, pix_acc_d, pix_b;
  logic [CNT_WIDTH-1:0] line_acc_q, line_acc_d, line_b;
  logic                 ovf_acc_q, ovf_acc_d, ovf_b;
  logic [SUM_WIDTH-1:0] stat_sum_q, stat_sum_d;
  logic [PW-1:0]        stat_min_q, stat_min_d, stat_max_q, stat_max_d;
  logic [PCW-1:0]       stat_pix_q, stat_pix_d;
  logic [CNT_WIDTH-1:0] stat_line_q, stat_line_d;
  logic                 stat_ovf_q, stat_ovf_d, stat_valid_q, stat_valid_d;
  logic                 de3, vs3, bound, de_fall, clr, on, acc, in_roi, done;
`ifdef LUMA_FRAME_STAT_ROI_EN
  logic [CNT_WIDTH-1:0] x_q, x_d, x;
`endif
  assign de3     = d3_q[3*PW];
  assign vs3     = d3_q[3*PW+2];
  assign bound   = vs3 & ~vs_prev_q;
  assign de_fall = ~de3 & de_prev_q;
  assign done    = state_q == S_DONE;
  always_comb begin
    p_d[0]  = PRW'(di_i[PW-1:0]) * PRW'(ycoe0_i);
    p_d[1]  = PRW'(di_i[2*PW-1:PW]) * PRW'(ycoe1_i);
    p_d[2]  = PRW'(di_i[3*PW-1:2*PW]) * PRW'(ycoe2_i);
    d1_d    = {vs_i, hs_i, de_i, di_i};
    d2_d    = d1_q;
    d3_d    = d2_q;
    s_d     = SW2'(p_q[0]) + SW2'(p_q[1]) + SW2'(p_q[2]);
    sh      = s_q >> COE_SHIFT;
    y_d     = (sh > SW2'((1 << PW) - 1)) ? '1 : sh[PW-1:0];
    de_prev_d = de3;
    vs_prev_d = vs3;
    // outside S_ACC the accumulators start from their cleared values
    clr     = state_q != S_ACC;
    on      = state_q != S_SYNC;
    sum_b   = clr ? '0 : sum_acc_q;
    min_b   = clr ? '1 : min_acc_q;
    max_b   = clr ? '0 : max_acc_q;
    pix_b   = clr ? '0 : pix_acc_q;
    line_b  = clr ? '0 : line_acc_q;
    ovf_b   = clr ? 1'b0 : ovf_acc_q;
`ifdef LUMA_FRAME_STAT_ROI_EN
    x       = (de3 & ~de_prev_q) ? '0 : x_q;
    x_d     = de3 ? x + CNT_WIDTH'(1) : x_q;
    in_roi  = x >= roi_x0_i && x <= roi_x1_i && line_b >= roi_y0_i && line_b <= roi_y1_i;
`else
    in_roi  = 1'b1;
`endif
    acc        = on & de3 & in_roi;
    sum_ext    = {1'b0, sum_b} + SW1'(y_q);
    sum_acc_d  = acc ? (sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0]) : sum_b;
    ovf_acc_d  = ovf_b | (acc & sum_ext[SUM_WIDTH]);
    min_acc_d  = acc && y_q < min_b ? y_q : min_b;
    max_acc_d  = acc && y_q > max_b ? y_q : max_b;
    pix_acc_d  = acc && ~&pix_b ? pix_b + PCW'(1) : pix_b;
    line_acc_d = on && de_fall && ~&line_b ? line_b + CNT_WIDTH'(1) : line_b;
    state_d    = state_q == S_SYNC ? (bound ? S_ACC : S_SYNC) :
                 state_q == S_ACC  ? (bound ? S_DONE : S_ACC) : S_ACC;
    stat_valid_d = done;
    stat_sum_d   = done ? sum_acc_q : stat_sum_q;
    stat_min_d   = done ? (pix_acc_q == '0 ? '0 : min_acc_q) : stat_min_q;
    stat_max_d   = done ? max_acc_q : stat_max_q;
    stat_pix_d   = done ? pix_acc_q : stat_pix_q;
    stat_line_d  = done ? line_acc_q : stat_line_q;
    stat_ovf_d   = done ? ovf_acc_q : stat_ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= S_SYNC;
      p_q          <= '{default: '0};
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      s_q          <= '0;
      y_q          <= '0;
      de_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      sum_acc_q    <= '0;
      min_acc_q    <= '0;
      max_acc_q    <= '0;
      pix_acc_q    <= '0;
      line_acc_q   <= '0;
      ovf_acc_q    <= 1'b0;
      stat_sum_q   <= '0;
      stat_min_q   <= '0;
      stat_max_q   <= '0;
      stat_pix_q   <= '0;
      stat_line_q  <= '0;
      stat_ovf_q   <= 1'b0;
      stat_valid_q <= 1'b0;
`ifdef LUMA_FRAME_STAT_ROI_EN
      x_q          <= '0;
`endif
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      d3_q         <= d3_d;
      s_q          <= s_d;
      y_q          <= y_d;
      de_prev_q    <= de_prev_d;
      vs_prev_q    <= vs_prev_d;
      sum_acc_q    <= sum_acc_d;
      min_acc_q    <= min_acc_d;
      max_acc_q    <= max_acc_d;
      pix_acc_q    <= pix_acc_d;
      line_acc_q   <= line_acc_d;
      ovf_acc_q    <= ovf_acc_d;
      stat_sum_q   <= stat_sum_d;
      stat_min_q   <= stat_min_d;
      stat_max_q   <= stat_max_d;
      stat_pix_q   <= stat_pix_d;
      stat_line_q  <= stat_line_d;
      stat_ovf_q   <= stat_ovf_d;
      stat_valid_q <= stat_valid_d;
`ifdef LUMA_FRAME_STAT_ROI_EN
      x_q          <= x_d;
`endif
    end
  assign do_o           = d3_q[3*PW-1:0];
  assign de_o           = de3;
  assign hs_o           = d3_q[3*PW+1];
  assign vs_o           = vs3;
  assign stat_sum_o     = stat_sum_q;
  assign stat_min_o     = stat_min_q;
  assign stat_max_o     = stat_max_q;
  assign stat_pixcnt_o  = stat_pix_q;
  assign stat_linecnt_o = stat_line_q;
  assign stat_ovf_o     = stat_ovf_q;
  assign stat_valid_o   = stat_valid_q;
endmodule

// File: tb/tb_luma_frame_stat.sv
// tb_luma_frame_stat: random/directed frames vs. a frame-level reference model, scoreboard-checked.
module tb_luma_frame_stat;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] c0 = 16'd19, c1 = 16'd37, c2 = 16'd9;
  logic [23:0] di = '0;
  logic de = 1'b0, hs = 1'b0, vs = 1'b0;
  logic [23:0] do_o, do_n, pix_o, pix_n;
  logic de_o, hs_o, vs_o, de_n, hs_n, vs_n, ovf_o, ovf_n, val_o, val_n;
  logic [31:0] sum_o;
  logic [9:0] sum_n;
  logic [7:0] min_o, max_o, min_n, max_n;
  logic [11:0] line_o, line_n;
  logic [11:0] roi_lo = '0, roi_hi = '1;
  typedef struct {longint sum; int mn; int mx; int pix; int line;} exp_t;
  exp_t exp_q[$];
  int compared = 0, mismatched = 0;
  bit synced = 0;
  longint m_sum = 0;
  int m_min = 255, m_max = 0, m_pix = 0, m_line = 0;
  logic m_prev_de = 1'b0, m_prev_vs = 1'b0;
  always #5 clk = ~clk;
  luma_frame_stat dut (
    .clk(clk), .rst_n(rst_n),
`ifdef LUMA_FRAME_STAT_ROI_EN
    .roi_x0_i(roi_lo), .roi_x1_i(roi_hi), .roi_y0_i(roi_lo), .roi_y1_i(roi_hi),
`endif
    .ycoe0_i(c0), .ycoe1_i(c1), .ycoe2_i(c2), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .stat_sum_o(sum_o),
    .stat_min_o(min_o), .stat_max_o(max_o), .stat_pixcnt_o(pix_o), .stat_linecnt_o(line_o),
    .stat_ovf_o(ovf_o), .stat_valid_o(val_o));
  luma_frame_stat #(.SUM_WIDTH(10)) dut_n (
    .clk(clk), .rst_n(rst_n),
`ifdef LUMA_FRAME_STAT_ROI_EN
    .roi_x0_i(roi_lo), .roi_x1_i(roi_hi), .roi_y0_i(roi_lo), .roi_y1_i(roi_hi),
`endif
    .ycoe0_i(c0), .ycoe1_i(c1), .ycoe2_i(c2), .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
    .do_o(do_n), .de_o(de_n), .hs_o(hs_n), .vs_o(vs_n), .stat_sum_o(sum_n),
    .stat_min_o(min_n), .stat_max_o(max_n), .stat_pixcnt_o(pix_n), .stat_linecnt_o(line_n),
    .stat_ovf_o(ovf_n), .stat_valid_o(val_n));
  task automatic chk(input string n, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, req, $time);
    end
  endtask
  function automatic int luma(input logic [23:0] p);
    int v;
    v = (int'(c0) * int'(p[7:0]) + int'(c1) * int'(p[15:8]) + int'(c2) * int'(p[23:16])) / 64;
    return v > 255 ? 255 : v;
  endfunction
  task automatic model_clear();
    m_sum = 0; m_min = 255; m_max = 0; m_pix = 0; m_line = 0;
  endtask
  // one input cycle; the model assigns every pixel and line end to the frame closed by the next vs rise
  task automatic step(input logic [23:0] p, input logic d, input logic h, input logic v, input bit nc);
    int y;
    @(posedge clk);
    #1;
    if (nc) begin
      c0 = 16'($urandom_range(0, 120));
      c1 = 16'($urandom_range(0, 120));
      c2 = 16'($urandom_range(0, 120));
    end
    di = p; de = d; hs = h; vs = v;
    if (synced && d) begin
      y = luma(p);
      m_sum += y;
      if (y < m_min) m_min = y;
      if (y > m_max) m_max = y;
      m_pix++;
    end
    if (synced && !d && m_prev_de) m_line++;
    if (v && !m_prev_vs) begin
      if (synced) exp_q.push_back('{m_sum, (m_pix > 0) ? m_min : 0, (m_pix > 0) ? m_max : 0, m_pix, m_line});
      synced = 1;
      model_clear();
    end
    m_prev_de = d; m_prev_vs = v;
  endtask
  // mode 0: constant grey v; 1: random pixels, new coefficients per frame; 2: new coefficients per line
  task automatic frame(input int w, input int h, input int mode, input logic [7:0] v);
    for (int l = 0; l < h; l++) begin
      step('0, 1'b0, 1'b1, 1'b0, (mode == 2) || (mode == 1 && l == 0));
      step('0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int x = 0; x < w; x++) step(mode != 0 ? 24'($urandom) : {v, v, v}, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step('0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      ok = val_o;
    end
    chk("valid_seen", ok, 1);
  endtask
  task automatic chk_reset_outs();
    chk("rst_do", {do_o, do_n}, 0);
    chk("rst_ctl", {de_o, hs_o, vs_o, val_o, ovf_o, de_n, hs_n, vs_n, val_n, ovf_n}, 0);
    chk("rst_sum", {sum_o, sum_n}, 0);
    chk("rst_minmax", {min_o, max_o, min_n, max_n}, 0);
    chk("rst_cnt", {pix_o, line_o}, 0);
    chk("rst_cnt_n", {pix_n, line_n}, 0);
  endtask
  always @(negedge clk) begin : mon
    logic [26:0] ph[$];
    logic [26:0] e;
    exp_t x;
    if (!rst_n) ph.delete();
    else begin
      ph.push_back({vs, hs, de, di});
      if (ph.size() == 4) begin
        e = ph.pop_front();
        chk("passthru", {vs_o, hs_o, de_o, do_o}, e);
        chk("passthru_n", {vs_n, hs_n, de_n, do_n}, e);
      end
      if (val_o || val_n) begin
        chk("valid_pair", {val_o, val_n}, 2'b11);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_valid: stat_valid_o high, no frame expected (t=%0t)", $time);
        end else begin
          x = exp_q.pop_front();
          chk("stat_sum", sum_o, x.sum);
          chk("stat_min", min_o, x.mn);
          chk("stat_max", max_o, x.mx);
          chk("stat_pixcnt", pix_o, x.pix);
          chk("stat_linecnt", line_o, x.line);
          chk("stat_ovf", ovf_o, 0);
          chk("sum_sat10", sum_n, x.sum > 1023 ? 1023 : x.sum);
          chk("ovf_sat10", ovf_n, x.sum > 1023 ? 1 : 0);
          chk("minmax_n", {min_n, max_n}, {x.mn[7:0], x.mx[7:0]});
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_outs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(3, 2, 0, 8'd128);
    frame(4, 2, 0, 8'd128);
    wait_valid();
    chk("f1_sum", sum_o, 1040);
    chk("f1_minmax", {min_o, max_o}, {8'd130, 8'd130});
    chk("f1_cnt", {pix_o, line_o}, {24'd8, 12'd2});
    chk("f1_sat10", {ovf_n, sum_n}, {1'b1, 10'd1023});
    frame(4, 2, 0, 8'd255);
    wait_valid();
    chk("clamp_sum", sum_o, 2040);
    chk("clamp_minmax", {min_o, max_o}, {8'd255, 8'd255});
    frame(0, 0, 0, 8'd0);
    wait_valid();
    chk("empty_stats", {sum_o, min_o, max_o, pix_o, line_o}, 0);
    frame(2, 1, 0, 8'd128);
    wait_valid();
    chk("clean_ovf_n", {ovf_n, sum_n}, {1'b0, 10'd260});
    for (int f = 0; f < 14; f++)
      frame($urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(1, 2), 8'd0);
    step('0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    di = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
    exp_q.delete();
    synced = 0; m_prev_de = 1'b0; m_prev_vs = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame(3, 3, 1, 8'd0);
    for (int f = 0; f < 6; f++)
      frame($urandom_range(1, 5), $urandom_range(1, 3), $urandom_range(1, 2), 8'd0);
    repeat (10) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
